// File: rtl/pipeline_stage_regs.sv
// rtl/pipeline_stage_regs.sv - IF/ID and ID/EX pipeline registers, PC write enable and HALT drain control
// Optional stall statistics outputs freeze_cnt/flush_cnt are built when PIPE_STALL_STATS_EN is defined.
module pipeline_stage_regs #(
    parameter int WORD_W    = 32,
    parameter int CTRL_W    = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dmem_pend,
    input  logic              freeze,
    input  logic              flush,
    input  logic              halt_dec,
    input  logic [WORD_W-1:0] if_instr,
    input  logic [WORD_W-1:0] if_npc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    output logic              pc_en,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_npc,
    output logic [WORD_W-1:0] idex_instr,
    output logic [WORD_W-1:0] idex_npc,
    output logic [WORD_W-1:0] idex_rdat1,
    output logic [WORD_W-1:0] idex_rdat2,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              idex_valid,
`ifdef PIPE_STALL_STATS_EN
    output logic              halted,
    output logic [31:0]       freeze_cnt,
    output logic [31:0]       flush_cnt
`else
    output logic              halted
`endif
);

    localparam int CNT_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [1:0] IF_HOLD = 2'd0;
    localparam logic [1:0] IF_LOAD = 2'd1;
    localparam logic [1:0] IF_NOP  = 2'd2;

    localparam logic [1:0] EX_HOLD   = 2'd0;
    localparam logic [1:0] EX_LOAD   = 2'd1;
    localparam logic [1:0] EX_BUBBLE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0] drain_cnt_nx;
    logic [1:0]       ifid_op;
    logic [1:0]       idex_op;

    logic run_st;
    logic drain_st;
    logic halted_st;
    logic halt_take;
    logic drain_done;

    assign run_st    = (state == ST_RUN);
    assign drain_st  = (state == ST_DRAIN);
    assign halted_st = (state == ST_HALTED);

    assign halt_take  = run_st && halt_dec && !flush && !freeze && !dmem_pend;
    assign drain_done = drain_st && !dmem_pend && !flush && (drain_cnt == '0);

    assign pc_en  = run_st && ihit && !dmem_pend && (!freeze || flush);
    assign halted = halted_st;

    // A flush during DRAIN means the HALT was on the wrong path, so fetch resumes.
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        if (!dmem_pend) begin
            case (state)
                ST_RUN: begin
                    if (halt_take) begin
                        state_nx     = ST_DRAIN;
                        drain_cnt_nx = DRAIN_LD;
                    end
                end
                ST_DRAIN: begin
                    if (flush) begin
                        state_nx     = ST_RUN;
                        drain_cnt_nx = '0;
                    end else if (drain_cnt == '0) begin
                        state_nx = ST_HALTED;
                    end else begin
                        drain_cnt_nx = drain_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nx     = ST_HALTED;
                    drain_cnt_nx = '0;
                end
            endcase
        end
    end

    // The younger fetch behind a HALT is discarded so nothing after HALT reaches EX.
    always_comb begin
        ifid_op = IF_HOLD;
        idex_op = EX_HOLD;
        if (dmem_pend) begin
            ifid_op = IF_HOLD;
            idex_op = EX_HOLD;
        end else if (flush || halted_st || drain_done) begin
            ifid_op = IF_NOP;
            idex_op = EX_BUBBLE;
        end else if (freeze) begin
            ifid_op = drain_st ? IF_NOP : IF_HOLD;
            idex_op = EX_BUBBLE;
        end else begin
            idex_op = EX_LOAD;
            ifid_op = (run_st && ihit && !halt_take) ? IF_LOAD : IF_NOP;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ifid_instr <= '0;
            ifid_npc   <= '0;
        end else begin
            case (ifid_op)
                IF_LOAD: begin
                    ifid_instr <= if_instr;
                    ifid_npc   <= if_npc;
                end
                IF_NOP: begin
                    ifid_instr <= '0;
                    ifid_npc   <= '0;
                end
                default: begin
                    ifid_instr <= ifid_instr;
                    ifid_npc   <= ifid_npc;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idex_instr <= '0;
            idex_npc   <= '0;
            idex_rdat1 <= '0;
            idex_rdat2 <= '0;
            idex_ctrl  <= '0;
            idex_valid <= 1'b0;
        end else begin
            case (idex_op)
                EX_LOAD: begin
                    idex_instr <= ifid_instr;
                    idex_npc   <= ifid_npc;
                    idex_rdat1 <= id_rdat1;
                    idex_rdat2 <= id_rdat2;
                    idex_ctrl  <= id_ctrl;
                    idex_valid <= (ifid_instr != '0);
                end
                EX_BUBBLE: begin
                    idex_instr <= '0;
                    idex_npc   <= '0;
                    idex_rdat1 <= '0;
                    idex_rdat2 <= '0;
                    idex_ctrl  <= '0;
                    idex_valid <= 1'b0;
                end
                default: begin
                    idex_instr <= idex_instr;
                    idex_npc   <= idex_npc;
                    idex_rdat1 <= idex_rdat1;
                    idex_rdat2 <= idex_rdat2;
                    idex_ctrl  <= idex_ctrl;
                    idex_valid <= idex_valid;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_STATS_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (freeze && !flush && !dmem_pend && (freeze_cnt != '1)) begin
                freeze_cnt <= freeze_cnt + 32'd1;
            end
            if (flush && !dmem_pend && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb/tb_pipeline_stage_regs.sv - self-checking bench for pipeline_stage_regs
module tb_pipeline_stage_regs;

    localparam int WORD_W    = 32;
    localparam int CTRL_W    = 16;
    localparam int DRAIN_CYC = 3;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              ihit = 1'b0;
    logic              dmem_pend = 1'b0;
    logic              freeze = 1'b0;
    logic              flush = 1'b0;
    logic              halt_dec = 1'b0;
    logic [WORD_W-1:0] if_instr = '0;
    logic [WORD_W-1:0] if_npc = '0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic [WORD_W-1:0] id_rdat1 = '0;
    logic [WORD_W-1:0] id_rdat2 = '0;
    logic              pc_en;
    logic [WORD_W-1:0] ifid_instr, ifid_npc;
    logic [WORD_W-1:0] idex_instr, idex_npc, idex_rdat1, idex_rdat2;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              idex_valid;
    logic              halted;

    pipeline_stage_regs #(.WORD_W(WORD_W), .CTRL_W(CTRL_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_pend(dmem_pend), .freeze(freeze),
        .flush(flush), .halt_dec(halt_dec), .if_instr(if_instr), .if_npc(if_npc),
        .id_ctrl(id_ctrl), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .pc_en(pc_en),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .idex_instr(idex_instr),
        .idex_npc(idex_npc), .idex_rdat1(idex_rdat1), .idex_rdat2(idex_rdat2),
        .idex_ctrl(idex_ctrl), .idex_valid(idex_valid), .halted(halted)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pipe contents as plain records, mode plus remaining drain edges.
    typedef enum int {M_RUN, M_DRAIN, M_HALTED} mode_t;
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] npc;
        logic [WORD_W-1:0] rdat1;
        logic [WORD_W-1:0] rdat2;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } ex_t;

    mode_t             m_mode;
    int                m_left;
    logic [WORD_W-1:0] m_ifid_instr, m_ifid_npc;
    ex_t               m_ex;
    logic              pc_en_seen, pc_en_exp;

    task automatic model_reset();
        m_mode = M_RUN;
        m_left = 0;
        m_ifid_instr = '0;
        m_ifid_npc = '0;
        m_ex = '0;
    endtask

    task automatic model_edge();
        logic [WORD_W-1:0] old_instr, old_npc;
        if (dmem_pend) return;
        old_instr = m_ifid_instr;
        old_npc = m_ifid_npc;
        if (flush) begin
            m_ifid_instr = '0; m_ifid_npc = '0; m_ex = '0;
            if (m_mode == M_DRAIN) begin m_mode = M_RUN; m_left = 0; end
            return;
        end
        if (m_mode == M_HALTED || (m_mode == M_DRAIN && m_left == 0)) begin
            m_ifid_instr = '0; m_ifid_npc = '0; m_ex = '0;
            m_mode = M_HALTED;
            return;
        end
        if (freeze) m_ex = '0;
        else m_ex = '{old_instr, old_npc, id_rdat1, id_rdat2, id_ctrl, old_instr != 0};
        if (m_mode == M_DRAIN) begin
            m_left = m_left - 1;
            m_ifid_instr = '0; m_ifid_npc = '0;
        end else if (halt_dec && !freeze) begin
            m_mode = M_DRAIN;
            m_left = DRAIN_CYC;
            m_ifid_instr = '0; m_ifid_npc = '0;
        end else if (!freeze) begin
            m_ifid_instr = ihit ? if_instr : '0;
            m_ifid_npc = ihit ? if_npc : '0;
        end
    endtask

    // Called on a falling edge; returns on the next falling edge with the model advanced.
    task automatic step(input logic i_ihit, input logic i_dp, input logic i_fz, input logic i_fl,
                        input logic i_hd, input logic [WORD_W-1:0] i_instr, input logic [WORD_W-1:0] i_npc);
        ihit = i_ihit; dmem_pend = i_dp; freeze = i_fz; flush = i_fl; halt_dec = i_hd;
        if_instr = i_instr; if_npc = i_npc;
        id_ctrl = CTRL_W'($urandom); id_rdat1 = $urandom; id_rdat2 = $urandom;
        #1;
        pc_en_seen = pc_en;
        pc_en_exp = (m_mode == M_RUN) && i_ihit && !i_dp && (!i_fz || i_fl);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        nRST = 1'b0;
        ihit = 1'b0; dmem_pend = 1'b0; freeze = 1'b0; flush = 1'b0; halt_dec = 1'b0;
        @(negedge CLK);
        model_reset();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #1;
        vectors++;
        if ({ifid_instr, ifid_npc, idex_instr, idex_npc, idex_rdat1, idex_rdat2, idex_ctrl, idex_valid, halted} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs got ifid=%h idex=%h valid=%b halted=%b want all 0", ifid_instr, idex_instr, idex_valid, halted);
        end
        apply_reset();
    endtask

    task automatic test_stream();
        step(1, 0, 0, 0, 0, 32'h8C220004, 32'h4);
        vectors++;
        if (ifid_instr !== 32'h8C220004 || ifid_npc !== 32'h4 || pc_en_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_1 got ifid=%h npc=%h pc_en=%b want 8c220004 4 1", ifid_instr, ifid_npc, pc_en_seen);
        end
        step(1, 0, 0, 0, 0, 32'h00430820, 32'h8);
        vectors++;
        if (ifid_instr !== 32'h00430820 || idex_instr !== 32'h8C220004 || idex_valid !== 1'b1 || pc_en_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_2 got ifid=%h idex=%h valid=%b pc_en=%b want 00430820 8c220004 1 1",
                     ifid_instr, idex_instr, idex_valid, pc_en_seen);
        end
    endtask

    task automatic test_freeze();
        step(1, 0, 1, 0, 0, 32'h11111111, 32'hC);
        vectors++;
        if (ifid_instr !== 32'h00430820 || idex_ctrl !== '0 || idex_valid !== 1'b0 || pc_en_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze got ifid=%h ctrl=%h valid=%b pc_en=%b want 00430820 0 0 0",
                     ifid_instr, idex_ctrl, idex_valid, pc_en_seen);
        end
        step(1, 0, 1, 1, 0, 32'h22222222, 32'h10);
        vectors++;
        if (ifid_instr !== '0 || {idex_instr, idex_npc, idex_rdat1, idex_rdat2, idex_ctrl, idex_valid} !== '0 || pc_en_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_flush got ifid=%h idex=%h valid=%b pc_en=%b want 0 0 0 1",
                     ifid_instr, idex_instr, idex_valid, pc_en_seen);
        end
    endtask

    task automatic test_dmem_pend();
        logic [WORD_W-1:0] keep_ifid;
        ex_t keep_ex;
        step(1, 0, 0, 0, 0, 32'h8C220004, 32'h14);
        step(1, 0, 0, 0, 0, 32'h00430820, 32'h18);
        keep_ifid = 32'h00430820;
        keep_ex = m_ex;
        for (int c = 0; c < 4; c++) begin
            step(1, 1, 0, c == 1, 0, 32'h33333333, 32'h1C);
            vectors++;
            if (ifid_instr !== keep_ifid || idex_instr !== 32'h8C220004 ||
                {idex_instr, idex_npc, idex_rdat1, idex_rdat2, idex_ctrl, idex_valid} !== keep_ex || pc_en_seen !== 1'b0) begin
                miscompares++;
                $display("FAIL dmem_hold_%0d got ifid=%h idex=%h pc_en=%b want %h 8c220004 0",
                         c, ifid_instr, idex_instr, pc_en_seen, keep_ifid);
            end
        end
        step(1, 0, 0, 0, 0, 32'h44444444, 32'h1C);
        vectors++;
        if (ifid_instr !== 32'h44444444 || idex_instr !== 32'h00430820 || idex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL dmem_release got ifid=%h idex=%h valid=%b want 44444444 00430820 1", ifid_instr, idex_instr, idex_valid);
        end
    endtask

    task automatic test_halt(input int stall_at);
        int edges;
        apply_reset();
        step(1, 0, 0, 0, 0, 32'hFC000000, 32'h4);
        step(1, 0, 0, 0, 1, 32'h55555555, 32'h8);
        vectors++;
        if (idex_instr !== 32'hFC000000 || idex_valid !== 1'b1 || ifid_instr !== '0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_enter got idex=%h valid=%b ifid=%h halted=%b want fc000000 1 0 0",
                     idex_instr, idex_valid, ifid_instr, halted);
        end
        edges = 0;
        while (halted !== 1'b1 && edges < 20) begin
            step(1, edges == stall_at, 0, 0, 0, 32'h66666666, 32'hC);
            edges++;
            vectors++;
            if (pc_en_seen !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_pc_en got %b want 0", pc_en_seen);
            end
        end
        vectors++;
        if (edges != DRAIN_CYC + 1 + (stall_at >= 0 ? 1 : 0)) begin
            miscompares++;
            $display("FAIL halt_latency got %0d edges want %0d", edges, DRAIN_CYC + 1 + (stall_at >= 0 ? 1 : 0));
        end
        step(1, 0, 0, 1, 0, 32'h77777777, 32'h10);
        step(1, 0, 0, 0, 0, 32'h77777777, 32'h10);
        vectors++;
        if (halted !== 1'b1 || pc_en_seen !== 1'b0 || ifid_instr !== '0 || {idex_instr, idex_valid} !== '0) begin
            miscompares++;
            $display("FAIL halted_sticky got halted=%b pc_en=%b ifid=%h idex=%h want 1 0 0 0",
                     halted, pc_en_seen, ifid_instr, idex_instr);
        end
    endtask

    task automatic test_halt_flush();
        apply_reset();
        step(1, 0, 0, 0, 0, 32'hFC000000, 32'h4);
        step(1, 0, 0, 0, 1, 32'h55555555, 32'h8);
        step(1, 0, 0, 1, 0, 32'h55555555, 32'h8);
        step(1, 0, 0, 0, 0, 32'h88888888, 32'h40);
        vectors++;
        if (pc_en_seen !== 1'b1 || halted !== 1'b0 || ifid_instr !== 32'h88888888) begin
            miscompares++;
            $display("FAIL halt_flush got pc_en=%b halted=%b ifid=%h want 1 0 88888888", pc_en_seen, halted, ifid_instr);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 32'h99999999, 32'h44);
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_flush_stays got halted=%b want 0", halted);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1, 0, 0, 0, 0, 32'hFC000000, 32'h4);
        step(1, 0, 0, 0, 1, 32'h12345678, 32'h8);
        ihit = 1'b1; dmem_pend = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        vectors++;
        if ({ifid_instr, idex_instr, idex_npc, idex_ctrl, idex_valid, halted} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got ifid=%h idex=%h valid=%b halted=%b want 0", ifid_instr, idex_instr, idex_valid, halted);
        end
        @(negedge CLK);
        model_reset();
        nRST = 1'b1;
        dmem_pend = 1'b0;
        step(1, 0, 0, 0, 0, 32'hABCD0001, 32'h4);
        vectors++;
        if (pc_en_seen !== 1'b1 || ifid_instr !== 32'hABCD0001 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_run got pc_en=%b ifid=%h halted=%b want 1 abcd0001 0", pc_en_seen, ifid_instr, halted);
        end
    endtask

    task automatic test_random();
        int halted_run;
        halted_run = 0;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if (halted_run > 3) begin
                apply_reset();
                halted_run = 0;
            end
            step($urandom_range(5, 0) != 0, $urandom_range(5, 0) == 0, $urandom_range(5, 0) == 0,
                 $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0,
                 ($urandom_range(7, 0) == 0) ? 32'h0 : $urandom, $urandom);
            halted_run = (m_mode == M_HALTED) ? halted_run + 1 : 0;
            vectors++;
            if (pc_en_seen !== pc_en_exp) begin
                miscompares++;
                $display("FAIL rand_pc_en n=%0d got %b want %b", n, pc_en_seen, pc_en_exp);
            end
            vectors++;
            if (ifid_instr !== m_ifid_instr || ifid_npc !== m_ifid_npc) begin
                miscompares++;
                $display("FAIL rand_ifid n=%0d got %h/%h want %h/%h", n, ifid_instr, ifid_npc, m_ifid_instr, m_ifid_npc);
            end
            vectors++;
            if ({idex_instr, idex_npc, idex_rdat1, idex_rdat2, idex_ctrl, idex_valid} !== m_ex) begin
                miscompares++;
                $display("FAIL rand_idex n=%0d got %h %h v=%b want %h %h v=%b", n, idex_instr, idex_ctrl, idex_valid,
                         m_ex.instr, m_ex.ctrl, m_ex.valid);
            end
            vectors++;
            if (halted !== (m_mode == M_HALTED)) begin
                miscompares++;
                $display("FAIL rand_halted n=%0d got %b want %b", n, halted, m_mode == M_HALTED);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_freeze();
        test_dmem_pend();
        test_halt(-1);
        test_halt(1);
        test_halt_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_regs.md
Name: pipeline_stage_regs

Overview:
- Owns the IF/ID and ID/EX pipeline registers and the PC write enable.
- Acts on the freeze/flush requests from the hazard unit and on memory-wait conditions, and inserts bubbles where needed.
- Contains a halt-drain state machine, so HALT retires only after all older instructions leave the pipe.
- Sits between fetch, decode and execute in the five-stage datapath.

Parameters:
- WORD_W, 32, width of instruction, PC and register data words
- CTRL_W, 16, width of the decoded control bundle carried into EX
- DRAIN_CYC, 3, non-stalled cycles needed to drain EX/MEM/WB after HALT

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch data valid this cycle
- dmem_pend  in  1  MEM stage waiting on dhit; global stall
- freeze  in  1  load-use hazard: hold IF/ID and PC, bubble into ID/EX
- flush  in  1  taken branch/jump: squash IF/ID and ID/EX
- halt_dec  in  1  ID stage holds a decoded HALT
- if_instr  in  WORD_W  fetched instruction
- if_npc  in  WORD_W  PC+4 of fetched instruction
- id_ctrl  in  CTRL_W  decoded control bundle
- id_rdat1, id_rdat2  in  WORD_W  register file read data
- pc_en  out  1  PC register write enable
- ifid_instr, ifid_npc  out  WORD_W  IF/ID contents
- idex_instr, idex_npc, idex_rdat1, idex_rdat2  out  WORD_W  ID/EX contents
- idex_ctrl  out  CTRL_W  ID/EX control bundle
- idex_valid  out  1  ID/EX holds a real instruction
- halted  out  1  pipeline fully drained after HALT; sticky

Behaviour:
- Reset (async, nRST=0):
  - All IF/ID and ID/EX fields = 0; idex_valid=0; halted=0.
  - State = RUN; drain counter = 0.
- pc_en is combinational: 1 only in RUN when ihit=1, dmem_pend=0 and (freeze=0 or flush=1). Otherwise 0.
- Per-edge priority, highest first:
  1. dmem_pend=1: both registers hold; drain counter holds.
  2. flush=1:
     - IF/ID loads 0 (NOP).
     - ID/EX loads bubble: all fields 0, idex_valid=0.
     - Flush beats freeze when both are set.
  3. freeze=1: IF/ID holds; ID/EX loads bubble.
  4. ihit=0: IF/ID loads NOP; ID/EX loads from ID stage normally.
  5. Otherwise:
     - IF/ID loads if_instr/if_npc.
     - ID/EX loads ID fields with idex_valid=1.
     - An all-zero ifid_instr gives idex_valid=0.
- RUN state: halt_dec=1, with flush=0, freeze=0, dmem_pend=0, moves to DRAIN.
  - The HALT itself moves into ID/EX on that edge.
  - Drain counter loads DRAIN_CYC.
- DRAIN state:
  - pc_en=0; IF/ID forced to NOP every non-stalled edge.
  - Counter decrements on each edge with dmem_pend=0.
  - When the counter reaches 0, move to HALTED.
  - flush=1 while DRAIN means the HALT was wrong-path: return to RUN, counter=0, normal flush action applies.
- HALTED state:
  - halted=1; pc_en=0.
  - IF/ID and ID/EX hold bubbles.
  - Exits only on reset.
- Reset asserted mid-DRAIN or mid-stall: immediate return to reset values; no partial state survives.
- Counter width is clog2(DRAIN_CYC+1); it never underflows.

Optional Feature:
- Macro: PIPE_STALL_STATS_EN.
- When defined, adds two outputs:
  - freeze_cnt (out, 32): counts edges where freeze=1 and flush=0 and dmem_pend=0.
  - flush_cnt (out, 32): counts edges where flush=1 and dmem_pend=0.
- Both counters saturate at 0xFFFFFFFF and clear on nRST.
- When undefined, these ports and counters do not exist and the block behaves identically otherwise.

Test Plan:
- Reset then stream: ihit=1, if_instr 0x8C220004 then 0x00430820 → IF/ID shows each one cycle later; idex_valid=1 one cycle after that; pc_en=1 throughout.
- freeze=1 for one cycle with IF/ID=0x00430820 → IF/ID holds 0x00430820; idex_ctrl=0 and idex_valid=0 next cycle; pc_en=0 during freeze.
- freeze=1 and flush=1 together → IF/ID=0 and ID/EX bubble next edge; pc_en=1 (flush wins).
- dmem_pend=1 for 4 cycles with a flush asserted in cycle 2 → registers unchanged for all 4 cycles; the flush has no effect until dmem_pend drops.
- halt_dec=1 in RUN, no stalls → halted=1 exactly DRAIN_CYC+1 edges later. With one dmem_pend cycle inserted during DRAIN, halted rises one cycle later.
- halt_dec, then flush=1 on the first DRAIN cycle → state back to RUN, halted stays 0, and pc_en returns to 1 on the next ihit.
